// File: rtl/rv32e_mem_arbiter.sv
// Shares one memory port between rv32e instruction fetch and data access.
// Data wins by default; a bounded data-grant streak guarantees fetch progress.
module rv32e_mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MAX_D_STREAK = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_gnt,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_be,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                err_spurious
);

   localparam int BE_W     = DATA_W / 8;
   localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic                  owner_data_q, owner_data_d;
   logic [STREAK_W-1:0]   streak_q, streak_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [BE_W-1:0]       mem_be_q, mem_be_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
   logic                  i_rvalid_q, i_rvalid_d;
   logic                  d_rvalid_q, d_rvalid_d;
   logic [DATA_W-1:0]     i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;
   logic                  err_q, err_d;

   logic                  streak_max_s;
   logic                  grant_d_s;
   logic                  grant_i_s;
   logic                  resp_done_s;

   assign streak_max_s = (streak_q == STREAK_W'(MAX_D_STREAK));
   assign resp_done_s  = (state_q == ST_RESP) && mem_rvalid;

   // Winner selection; only meaningful while idle.
   always_comb begin
      grant_d_s = 1'b0;
      grant_i_s = 1'b0;
      if (state_q == ST_IDLE) begin
         if (d_req && !(i_req && streak_max_s)) begin
            grant_d_s = 1'b1;
         end else if (i_req) begin
            grant_i_s = 1'b1;
         end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
         end
      end else begin
         grant_d_s = 1'b0;
         grant_i_s = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_d_s || grant_i_s) begin
               state_d = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (mem_gnt) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_RESP: begin
            if (mem_rvalid) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: grants are combinational, everything else comes from flops.
   always_comb begin
      i_gnt        = grant_i_s;
      d_gnt        = grant_d_s;
      i_rvalid     = i_rvalid_q;
      i_rdata      = i_rdata_q;
      d_rvalid     = d_rvalid_q;
      d_rdata      = d_rdata_q;
      mem_req      = mem_req_q;
      mem_we       = mem_we_q;
      mem_be       = mem_be_q;
      mem_addr     = mem_addr_q;
      mem_wdata    = mem_wdata_q;
      err_spurious = err_q;
   end

   // Command capture, streak bookkeeping and response steering.
   always_comb begin
      owner_data_d = owner_data_q;
      streak_d     = streak_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_be_d     = mem_be_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;

      if (grant_d_s) begin
         owner_data_d = 1'b1;
         mem_req_d    = 1'b1;
         mem_we_d     = d_we;
         mem_be_d     = d_be;
         mem_addr_d   = d_addr;
         mem_wdata_d  = d_wdata;
         // Only data grants that make a fetch wait count toward the streak.
         if (!i_req) begin
            streak_d = {STREAK_W{1'b0}};
         end else if (streak_max_s) begin
            streak_d = streak_q;
         end else begin
            streak_d = streak_q + STREAK_W'(1);
         end
      end else if (grant_i_s) begin
         owner_data_d = 1'b0;
         mem_req_d    = 1'b1;
         mem_we_d     = 1'b0;
         mem_be_d     = {BE_W{1'b1}};
         mem_addr_d   = i_addr;
         mem_wdata_d  = {DATA_W{1'b0}};
         streak_d     = {STREAK_W{1'b0}};
      end else if ((state_q == ST_REQ) && mem_gnt) begin
         mem_req_d = 1'b0;
      end else begin
         mem_req_d = mem_req_q;
      end

      i_rvalid_d = resp_done_s && !owner_data_q;
      d_rvalid_d = resp_done_s && owner_data_q;

      if (i_rvalid_d) begin
         i_rdata_d = mem_rdata;
      end else begin
         i_rdata_d = i_rdata_q;
      end

      if (d_rvalid_d) begin
         d_rdata_d = mem_we_q ? {DATA_W{1'b0}} : mem_rdata;
      end else begin
         d_rdata_d = d_rdata_q;
      end

      err_d = err_q || (mem_rvalid && (state_q != ST_RESP));
   end

   // Datapath and status registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_data_q <= 1'b0;
         streak_q     <= {STREAK_W{1'b0}};
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_be_q     <= {BE_W{1'b0}};
         mem_addr_q   <= {ADDR_W{1'b0}};
         mem_wdata_q  <= {DATA_W{1'b0}};
         i_rvalid_q   <= 1'b0;
         d_rvalid_q   <= 1'b0;
         i_rdata_q    <= {DATA_W{1'b0}};
         d_rdata_q    <= {DATA_W{1'b0}};
         err_q        <= 1'b0;
      end else begin
         owner_data_q <= owner_data_d;
         streak_q     <= streak_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_be_q     <= mem_be_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         i_rvalid_q   <= i_rvalid_d;
         d_rvalid_q   <= d_rvalid_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         err_q        <= err_d;
      end
   end

endmodule

// File: tb/tb_rv32e_mem_arbiter.sv
// Scoreboard bench for rv32e_mem_arbiter: random and directed requester traffic against
// a transaction-level arbitration model and a behavioural memory responder.
module tb_rv32e_mem_arbiter;

   localparam int MAXS = 4;

   logic        clk;
   logic        rst_n;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        err_spurious;

   rv32e_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS)) dut (
      .clk(clk), .reset(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .err_spurious(err_spurious)
   );

   typedef struct { logic owner_data; logic [31:0] data; } resp_t;
   typedef struct { logic fetch; logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } cmd_t;

   resp_t resp_q[$];
   cmd_t  cmd_q[$];
   int    checks = 0;
   int    errors = 0;

   // Memory responder knobs, set by the main sequence.
   int unsigned gnt_pct      = 100;
   int unsigned max_lat      = 0;
   int unsigned stall_cycles = 0;
   logic        hold_rvalid  = 1'b0;
   logic        force_rvalid = 1'b0;
   logic        pend         = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] rd_fn(input logic [31:0] a);
      if (a == 32'h0000_0008) return 32'h0020_8463;
      return {a[15:0], ~a[31:16]} ^ 32'hC3A5_0F1E;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: arbitration model plus response scoreboard.
   initial begin : monitor
      resp_t r;
      cmd_t  c;
      logic  exp_i, exp_d, outst;
      int    m_streak;
      outst    = 1'b0;
      m_streak = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            resp_q.delete();
            cmd_q.delete();
            outst    = 1'b0;
            m_streak = 0;
         end else begin
            if (i_rvalid || d_rvalid) begin
               if (resp_q.size() == 0) begin
                  chk("rvalid_unexpected", {30'd0, i_rvalid, d_rvalid}, 32'd0);
               end else begin
                  r = resp_q.pop_front();
                  chk("rvalid_owner", {30'd0, i_rvalid, d_rvalid}, r.owner_data ? 32'd1 : 32'd2);
                  chk("rdata", r.owner_data ? d_rdata : i_rdata, r.data);
               end
               outst = 1'b0;
            end
            exp_i = 1'b0;
            exp_d = 1'b0;
            if (!outst) begin
               if (d_req && !(i_req && m_streak == MAXS)) exp_d = 1'b1;
               else if (i_req) exp_i = 1'b1;
            end
            chk("grant", {30'd0, i_gnt, d_gnt}, {30'd0, exp_i, exp_d});
            if (exp_d) begin
               c.fetch = 1'b0; c.we = d_we; c.be = d_be; c.addr = d_addr; c.wdata = d_wdata;
               r.owner_data = 1'b1;
               r.data = d_we ? 32'd0 : rd_fn(d_addr);
               if (!i_req) m_streak = 0;
               else if (m_streak < MAXS) m_streak++;
            end else if (exp_i) begin
               c.fetch = 1'b1; c.we = 1'b0; c.be = 4'hF; c.addr = i_addr; c.wdata = 32'd0;
               r.owner_data = 1'b0;
               r.data = rd_fn(i_addr);
               m_streak = 0;
            end
            if (exp_d || exp_i) begin
               cmd_q.push_back(c);
               resp_q.push_back(r);
               outst = 1'b1;
            end
         end
      end
   end

   // Memory responder: random accept delay and latency, checks commands as they are accepted.
   initial begin : responder
      cmd_t        cc;
      logic [31:0] p_addr;
      logic        p_we;
      int unsigned lat_cnt, stall_cnt;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
      lat_cnt = 0; stall_cnt = 0; p_addr = 32'd0; p_we = 1'b0;
      forever begin
         @(negedge clk);
         mem_gnt    = 1'b0;
         mem_rvalid = force_rvalid;
         mem_rdata  = $urandom;
         if (!rst_n) begin
            pend = 1'b0; stall_cnt = 0; mem_rvalid = 1'b0;
         end else if (pend) begin
            chk("mem_req_in_resp", 32'(mem_req), 32'd0);
            if (!hold_rvalid && lat_cnt == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = p_we ? $urandom : rd_fn(p_addr);
               pend = 1'b0;
            end else if (lat_cnt > 0) begin
               lat_cnt--;
            end
         end else if (mem_req) begin
            if (cmd_q.size() == 0) begin
               chk("mem_req_unexpected", 32'(mem_req), 32'd0);
            end else begin
               chk("mem_addr_hold", mem_addr, cmd_q[0].addr);
               if (stall_cnt < stall_cycles) begin
                  stall_cnt++;
               end else if ($urandom_range(0, 99) < gnt_pct) begin
                  mem_gnt = 1'b1;
                  cc = cmd_q.pop_front();
                  chk("mem_we", 32'(mem_we), 32'(cc.we));
                  if (cc.we || cc.fetch) chk("mem_be", 32'(mem_be), 32'(cc.be));
                  if (cc.we) chk("mem_wdata", mem_wdata, cc.wdata);
                  p_addr = mem_addr; p_we = mem_we;
                  lat_cnt = $urandom_range(0, max_lat);
                  stall_cnt = 0;
                  pend = 1'b1;
               end
            end
         end
      end
   end

   task automatic do_reset();
      i_req = 1'b0; d_req = 1'b0;
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while ((resp_q.size() != 0 || pend) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(resp_q.size()), 32'd0);
   endtask

   initial begin : main
      int k, cnt;
      logic gi, gd;
      i_req = 1'b0; i_addr = 32'd0; d_req = 1'b0; d_we = 1'b0; d_be = 4'd0;
      d_addr = 32'd0; d_wdata = 32'd0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
      chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      chk("rst_err", 32'(err_spurious), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Lone fetch with minimum latency.
      @(posedge clk); #1 i_req = 1'b1; i_addr = 32'h0000_0008;
      @(negedge clk); chk("fetch_gnt_T", 32'(i_gnt), 32'd1);
      @(posedge clk); #1 i_req = 1'b0;
      @(negedge clk);
      chk("fetch_mem_req_T1", 32'(mem_req), 32'd1);
      chk("fetch_mem_addr", mem_addr, 32'h0000_0008);
      chk("fetch_mem_we", 32'(mem_we), 32'd0);
      chk("fetch_mem_be", 32'(mem_be), 32'hF);
      @(negedge clk); chk("fetch_no_rvalid_T2", 32'(i_rvalid), 32'd0);
      @(negedge clk);
      chk("fetch_rvalid_T3", 32'(i_rvalid), 32'd1);
      chk("fetch_rdata", i_rdata, 32'h0020_8463);

      // Data write.
      @(posedge clk); #1 d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF;
      @(negedge clk); chk("wr_gnt", 32'(d_gnt), 32'd1);
      @(posedge clk); #1 d_req = 1'b0;
      @(negedge clk);
      chk("wr_mem_we", 32'(mem_we), 32'd1);
      chk("wr_mem_be", 32'(mem_be), 32'b0011);
      chk("wr_mem_addr", mem_addr, 32'h100);
      chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      @(negedge clk);
      @(negedge clk);
      chk("wr_rvalid", 32'(d_rvalid), 32'd1);
      chk("wr_rdata_zero", d_rdata, 32'd0);
      chk("wr_i_rdata_hold", i_rdata, 32'h0020_8463);

      // Simultaneous requests from reset: data first, fetch three cycles later.
      do_reset();
      @(posedge clk); #1 i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
      @(negedge clk); chk("simul_first", {30'd0, i_gnt, d_gnt}, 32'd1);
      @(posedge clk); #1 d_req = 1'b0;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!i_gnt && cnt < 20);
      chk("simul_fetch_delay", 32'(cnt), 32'd3);
      @(posedge clk); #1 i_req = 1'b0;
      drain("simul_drain");

      // Continuous contention: D,D,D,D,I repeating.
      do_reset();
      @(posedge clk); #1 i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = $urandom; d_addr = $urandom;
      k = 0;
      for (int n = 0; n < 200 && k < 10; n++) begin
         @(negedge clk);
         gi = i_gnt; gd = d_gnt;
         if (gi || gd) begin
            chk("streak_order", {30'd0, gi, gd}, (k % 5 == 4) ? 32'd2 : 32'd1);
            k++;
         end
         @(posedge clk); #1;
         if (gi) i_addr = $urandom;
         if (gd) d_addr = $urandom;
      end
      chk("streak_grant_count", 32'(k), 32'd10);
      i_req = 1'b0; d_req = 1'b0;
      drain("streak_drain");

      // Memory holds off mem_gnt for five cycles.
      stall_cycles = 5;
      @(posedge clk); #1 i_req = 1'b1; i_addr = 32'h40;
      @(negedge clk); chk("stall_gnt", 32'(i_gnt), 32'd1);
      @(posedge clk); #1 i_req = 1'b0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         chk("stall_mem_req", 32'(mem_req), 32'd1);
         chk("stall_mem_addr", mem_addr, 32'h40);
      end
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!i_rvalid && cnt < 20);
      chk("stall_rvalid_seen", 32'(i_rvalid), 32'd1);
      stall_cycles = 0;

      // Randomized traffic.
      gnt_pct = 60; max_lat = 3;
      fork
         begin
            logic g1;
            for (int c = 0; c < 400; c++) begin
               @(negedge clk); g1 = i_gnt;
               @(posedge clk); #1;
               if (g1 || !i_req) begin
                  i_req = ($urandom_range(0, 99) < 50);
                  i_addr = $urandom;
               end
            end
            i_req = 1'b0;
         end
         begin
            logic g2;
            for (int c = 0; c < 400; c++) begin
               @(negedge clk); g2 = d_gnt;
               @(posedge clk); #1;
               if (g2 || !d_req) begin
                  d_req = ($urandom_range(0, 99) < 70);
                  d_we = $urandom_range(0, 1) == 1;
                  d_be = 4'($urandom_range(1, 15));
                  d_addr = $urandom;
                  d_wdata = $urandom;
               end
            end
            d_req = 1'b0;
         end
      join
      drain("random_drain");
      chk("random_no_spurious", 32'(err_spurious), 32'd0);
      gnt_pct = 100; max_lat = 0;

      // Reset while in RESP, then a late memory response.
      hold_rvalid = 1'b1;
      @(posedge clk); #1 d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
      @(negedge clk); chk("rst_resp_gnt", 32'(d_gnt), 32'd1);
      @(posedge clk); #1 d_req = 1'b0;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!pend && cnt < 20);
      chk("rst_resp_pending", 32'(pend), 32'd1);
      @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_resp_mem_req", 32'(mem_req), 32'd0);
      chk("rst_resp_d_rvalid", 32'(d_rvalid), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1; hold_rvalid = 1'b0; force_rvalid = 1'b1;
      @(posedge clk); #1 force_rvalid = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("late_no_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
      end
      chk("late_err_spurious", 32'(err_spurious), 32'd1);
      @(posedge clk); #1 i_req = 1'b1; i_addr = 32'h600;
      @(negedge clk); chk("post_reset_idle_gnt", 32'(i_gnt), 32'd1);
      @(posedge clk); #1 i_req = 1'b0;
      drain("final_drain");
      chk("err_sticky", 32'(err_spurious), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
